shot_controller: RTL and testbench
==================================

// Module: shot_controller
// PURPOSE
// - Battleship game sequencer between the debounced fire button / cursor logic and the VGA grid renderer.
// - Owns the 10x10 board state (UNKNOWN/MISS/HIT) and accepts fire requests at cursor coordinates via a req/ack handshake.
// - Resolves each shot against the ship layout and keeps score and shot count.
// - Serves a registered per-cell read port so the renderer can colour cells.
// PARAMETERS
// - GRID_SIZE   10   cells per row/column; cell index = row*GRID_SIZE + col
// - SHIP_CELLS  17   total ship cells; a hit count reaching this ends the game
// - HIT_POINTS  10   score increment per new hit
// - SCORE_W     16   score width
// PORTS
// - clk         in   1    system clock (single clock domain)
// - reset_n     in   1    asynchronous, active-low reset
// - start       in   1    one-cycle pulse: latch ship_mask, clear board/score/shots, enter PLAY
// - ship_mask   in   100  1 = ship at index; sampled only on start
// - fire_req    in   1    level request from cursor logic
// - fire_row    in   4    target row; held stable while fire_req is high
// - fire_col    in   4    target column; held stable while fire_req is high
// - fire_ack    out  1    one-cycle pulse; result is valid in the same cycle
// - result      out  2    0=MISS 1=HIT 2=REPEAT 3=INVALID; holds until the next ack
// - rd_row      in   4    renderer query row
// - rd_col      in   4    renderer query column
// - rd_state    out  2    0=UNKNOWN 1=MISS 2=HIT; registered, 1-cycle latency
// - score       out  SCORE_W  running score
// - shots       out  8    counted shots (MISS + HIT only), saturates at 255
// - game_over   out  1    high in OVER state
// - busy        out  1    high in CHECK or RESP
// BEHAVIOUR
// - Reset: state=IDLE; board all UNKNOWN; ship map 0; all outputs 0.
// - FSM states: IDLE, PLAY, CHECK, RESP, WAIT_REL, OVER.
// - start: from any state, on the next edge go to PLAY, latch ship_mask, clear board, set score=shots=hits=0.
//   - start has priority over a fire request in the same cycle; an in-flight shot is dropped with no ack.
// - PLAY: fire_req=1 at edge k latches row/col -> CHECK.
// - CHECK (edge k+1): classify the latched target.
//   - INVALID: row or col >= GRID_SIZE; takes precedence over all other checks.
//   - REPEAT: cell is not UNKNOWN.
//   - HIT: ship bit set.
//   - MISS: otherwise.
//   - Board write for HIT/MISS, result register and counter updates all take effect at edge k+2 -> RESP.
// - RESP: fire_ack=1 for exactly one cycle, during the cycle after edge k+2.
//   - Next state is OVER if hits==SHIP_CELLS, else WAIT_REL.
// - WAIT_REL: stay until fire_req=0, then PLAY. A held button yields exactly one shot.
// - OVER: fire_req ignored (no ack); score/shots frozen; game_over=1 until start or reset.
// - IDLE: fire_req ignored; no ack.
// - Arithmetic:
//   - score += HIT_POINTS on HIT only, wraps modulo 2^SCORE_W.
//   - shots += 1 on HIT or MISS, saturates at 255.
//   - hits is an internal counter (width clog2(SHIP_CELLS+1)).
// - Read port: rd_state <= board[rd_row*GRID_SIZE+rd_col] every cycle in all states.
//   - Returns 0 if rd_row or rd_col is out of range.
//   - If a board write and a read hit the same cell on one edge, the read returns the old value.
// STRUCTURE
// - battleship_pkg: GRID_SIZE, cell-state codes, result codes, FSM state encoding, index function row*GRID_SIZE+col.
// - Sub-module board_regfile: 100 x 2-bit registers, one synchronous write port, one registered read port, synchronous clear-all input.
// - shot_controller holds the FSM, ship map, counters and result register.
// TESTING
// - Reset, then start with a mask that has a ship at index 23 only (SHIP_CELLS=1 override):
//   - fire (2,3) -> ack 2 cycles after acceptance, result=HIT, score=10, shots=1, then game_over=1.
// - Fire (0,0) with no ship -> result=MISS, shots=1, score=0; rd_row/rd_col=(0,0) -> rd_state=1 one cycle later.
// - Fire (0,0) again after release -> result=REPEAT; shots and score unchanged.
// - Fire (10,4) -> result=INVALID; board unchanged.
// - Hold fire_req high for 50 cycles -> exactly one ack; a second ack only after a low-then-high on fire_req.
// - Reset and start tests:
//   - Pulse start in the CHECK cycle -> no ack; board, score and shots cleared.
//   - Assert reset_n=0 mid-RESP -> all outputs 0 immediately.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship shot sequencer.
// - Grid geometry, cell-state and shot-result codes, FSM state encoding.
// - cell_idx(): flat board index row*GRID_SIZE+col.
// - in_grid(): both coordinates within the board.
package battleship_pkg;

  localparam int GRID_SIZE = 10;
  localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
  localparam int IDX_W     = $clog2(NUM_CELLS);
  localparam int COORD_W   = 4;

  typedef enum logic [1:0] {
    CELL_UNKNOWN = 2'd0,
    CELL_MISS    = 2'd1,
    CELL_HIT     = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    RES_MISS    = 2'd0,
    RES_HIT     = 2'd1,
    RES_REPEAT  = 2'd2,
    RES_INVALID = 2'd3
  } res_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_CHECK    = 3'd2,
    ST_RESP     = 3'd3,
    ST_WAIT_REL = 3'd4,
    ST_OVER     = 3'd5
  } state_t;

  function automatic logic in_grid(input logic [COORD_W-1:0] row,
                                   input logic [COORD_W-1:0] col);
    return (int'(row) < GRID_SIZE) && (int'(col) < GRID_SIZE);
  endfunction

  // Only meaningful for in-grid coordinates; callers gate with in_grid().
  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] row,
                                                input logic [COORD_W-1:0] col);
    logic [7:0] t;
    t = 8'(row) * 8'(GRID_SIZE) + 8'(col);
    return t[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/board_regfile.sv
// Board state storage: NUM_CELLS x 2-bit cell registers.
// Ports:
//   clk, reset_n   clock, async active-low reset (all cells UNKNOWN)
//   clr            synchronous clear of every cell to UNKNOWN
//   we/wr_idx/wr_data   single synchronous write port
//   rd_vld/rd_idx  registered read request; rd_data returns 0 when !rd_vld
//   rd_data        registered read data, 1-cycle latency, old value on
//                  same-edge write
//   pk_idx/pk_data combinational peek used by the shot classifier
module board_regfile
  import battleship_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [1:0]       wr_data,
  input  logic             rd_vld,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_data,
  input  logic [IDX_W-1:0] pk_idx,
  output logic [1:0]       pk_data
);

  logic [NUM_CELLS-1:0][1:0] cells_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cells_q <= '0;
    end else if (clr) begin
      cells_q <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (wr_idx == IDX_W'(i)) cells_q[i] <= wr_data;
      end
    end
  end

  // Reads sample cells_q before this edge's write lands, so a same-cell
  // write/read pair returns the previous contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    rd_data <= '0;
    else if (rd_vld) rd_data <= cells_q[rd_idx];
    else             rd_data <= '0;
  end

  assign pk_data = cells_q[pk_idx];

endmodule

// File: rtl/shot_controller.sv
// Battleship shot sequencer.
// Accepts fire requests at cursor coordinates over a level req / pulse ack
// handshake, classifies each shot against the latched ship layout, updates
// the board, score and shot counters, and serves a registered cell read
// port for the renderer.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start, ship_mask      new game: latch mask, clear board/counters
//   fire_req/row/col      shot request (level, coords held while high)
//   fire_ack, result      one-cycle ack, result code held until next ack
//   rd_row/rd_col/rd_state  renderer cell query, 1-cycle latency
//   score, shots          running score (wraps), counted shots (saturates)
//   game_over, busy       OVER state; shot in CHECK/RESP
module shot_controller
  import battleship_pkg::*;
#(
  parameter int SHIP_CELLS = 17,
  parameter int HIT_POINTS = 10,
  parameter int SCORE_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NUM_CELLS-1:0] ship_mask,
  input  logic                 fire_req,
  input  logic [COORD_W-1:0]   fire_row,
  input  logic [COORD_W-1:0]   fire_col,
  output logic                 fire_ack,
  output logic [1:0]           result,
  input  logic [COORD_W-1:0]   rd_row,
  input  logic [COORD_W-1:0]   rd_col,
  output logic [1:0]           rd_state,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           shots,
  output logic                 game_over,
  output logic                 busy
);

  localparam int HITS_W = $clog2(SHIP_CELLS + 1);

  state_t               state_q, state_d;
  logic                 chk_ph_q;   // 0: classify cycle, 1: commit cycle
  logic [COORD_W-1:0]   tgt_row_q, tgt_col_q;
  res_t                 cls_q, cls_d;
  res_t                 result_q;
  logic [NUM_CELLS-1:0] ship_q;
  logic [SCORE_W-1:0]   score_q;
  logic [7:0]           shots_q;
  logic [HITS_W-1:0]    hits_q;

  logic                 tgt_ok, rd_ok, commit, we;
  logic [IDX_W-1:0]     tgt_idx, rd_idx;
  logic [1:0]           pk_data, wr_data;

  // ---------------- board storage ----------------
  assign tgt_ok  = in_grid(tgt_row_q, tgt_col_q);
  assign tgt_idx = tgt_ok ? cell_idx(tgt_row_q, tgt_col_q) : '0;
  assign rd_ok   = in_grid(rd_row, rd_col);
  assign rd_idx  = rd_ok ? cell_idx(rd_row, rd_col) : '0;

  assign commit  = (state_q == ST_CHECK) && chk_ph_q;
  // start drops the in-flight shot, so it also suppresses its board write.
  assign we      = commit && !start && ((cls_q == RES_HIT) || (cls_q == RES_MISS));
  assign wr_data = (cls_q == RES_HIT) ? CELL_HIT : CELL_MISS;

  board_regfile u_board (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start),
    .we      (we),
    .wr_idx  (tgt_idx),
    .wr_data (wr_data),
    .rd_vld  (rd_ok),
    .rd_idx  (rd_idx),
    .rd_data (rd_state),
    .pk_idx  (tgt_idx),
    .pk_data (pk_data)
  );

  // ---------------- classification ----------------
  // Out-of-range wins over everything; then an already-resolved cell.
  always_comb begin
    cls_d = RES_MISS;
    if (!tgt_ok)                     cls_d = RES_INVALID;
    else if (pk_data != CELL_UNKNOWN) cls_d = RES_REPEAT;
    else if (ship_q[tgt_idx])        cls_d = RES_HIT;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     state_d = ST_IDLE;
      ST_PLAY:     if (fire_req) state_d = ST_CHECK;
      ST_CHECK:    if (chk_ph_q) state_d = ST_RESP;
      ST_RESP:     state_d = (hits_q == HITS_W'(SHIP_CELLS)) ? ST_OVER : ST_WAIT_REL;
      ST_WAIT_REL: if (!fire_req) state_d = ST_PLAY;
      ST_OVER:     state_d = ST_OVER;
      default:     state_d = ST_IDLE;
    endcase
    if (start) state_d = ST_PLAY;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_ph_q  <= 1'b0;
      tgt_row_q <= '0;
      tgt_col_q <= '0;
      cls_q     <= RES_MISS;
      result_q  <= RES_MISS;
      ship_q    <= '0;
      score_q   <= '0;
      shots_q   <= '0;
      hits_q    <= '0;
    end else if (start) begin
      chk_ph_q <= 1'b0;
      ship_q   <= ship_mask;
      score_q  <= '0;
      shots_q  <= '0;
      hits_q   <= '0;
    end else begin
      if (state_q == ST_PLAY && fire_req) begin
        tgt_row_q <= fire_row;
        tgt_col_q <= fire_col;
        chk_ph_q  <= 1'b0;
      end
      if (state_q == ST_CHECK && !chk_ph_q) begin
        cls_q    <= cls_d;
        chk_ph_q <= 1'b1;
      end
      if (commit) begin
        chk_ph_q <= 1'b0;
        result_q <= cls_q;
        if (cls_q == RES_HIT) begin
          score_q <= score_q + SCORE_W'(HIT_POINTS);
          hits_q  <= hits_q + 1'b1;
        end
        if ((cls_q == RES_HIT || cls_q == RES_MISS) && shots_q != 8'hFF)
          shots_q <= shots_q + 8'd1;
      end
    end
  end

  assign fire_ack  = (state_q == ST_RESP);
  assign busy      = (state_q == ST_CHECK) || (state_q == ST_RESP);
  assign game_over = (state_q == ST_OVER);
  assign result    = result_q;
  assign score     = score_q;
  assign shots     = shots_q;

endmodule

// File: tb/tb_shot_controller.sv
module tb_shot_controller;

  logic        clk = 1'b0;
  logic        reset_n, start, fire_req;
  logic [99:0] ship_mask;
  logic [3:0]  fire_row, fire_col, rd_row, rd_col;

  logic        d_ack, d_go, d_busy;
  logic [1:0]  d_result, d_rd;
  logic [15:0] d_score;
  logic [7:0]  d_shots;
  logic        o_ack, o_go, o_busy;
  logic [1:0]  o_result, o_rd;
  logic [15:0] o_score;
  logic [7:0]  o_shots;

  int ncmp = 0;
  int nfail = 0;

  // reference model: plain board/ship arrays and counters
  int m_board[100];
  bit m_ship[100];
  int m_score, m_shots, m_hits;
  bit m_play, m_over;

  always #5 clk = ~clk;

  shot_controller u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ship_mask(ship_mask),
    .fire_req(fire_req), .fire_row(fire_row), .fire_col(fire_col),
    .fire_ack(d_ack), .result(d_result), .rd_row(rd_row), .rd_col(rd_col),
    .rd_state(d_rd), .score(d_score), .shots(d_shots), .game_over(d_go),
    .busy(d_busy)
  );

  shot_controller #(.SHIP_CELLS(1)) u_one (
    .clk(clk), .reset_n(reset_n), .start(start), .ship_mask(ship_mask),
    .fire_req(fire_req), .fire_row(fire_row), .fire_col(fire_col),
    .fire_ack(o_ack), .result(o_result), .rd_row(rd_row), .rd_col(rd_col),
    .rd_state(o_rd), .score(o_score), .shots(o_shots), .game_over(o_go),
    .busy(o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 100; i++) begin m_board[i] = 0; m_ship[i] = 0; end
    m_score = 0; m_shots = 0; m_hits = 0; m_play = 0; m_over = 0;
  endtask

  task automatic m_start(input logic [99:0] mask);
    for (int i = 0; i < 100; i++) begin m_board[i] = 0; m_ship[i] = mask[i]; end
    m_score = 0; m_shots = 0; m_hits = 0; m_play = 1; m_over = 0;
  endtask

  // 0=MISS 1=HIT 2=REPEAT 3=INVALID
  task automatic m_shoot(input int r, input int c, output int res);
    int idx;
    idx = r * 10 + c;
    if (r >= 10 || c >= 10) res = 3;
    else if (m_board[idx] != 0) res = 2;
    else if (m_ship[idx]) begin
      res = 1; m_board[idx] = 2;
      m_score = (m_score + 10) % 65536;
      if (m_shots < 255) m_shots++;
      m_hits++;
      if (m_hits == 17) begin m_over = 1; m_play = 0; end
    end else begin
      res = 0; m_board[idx] = 1;
      if (m_shots < 255) m_shots++;
    end
  endtask

  task automatic do_start(input logic [99:0] mask);
    ship_mask = mask; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_start(mask);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, d_ack, 0);
    chk({tag, "_result"}, d_result, 0);
    chk({tag, "_rd"}, d_rd, 0);
    chk({tag, "_score"}, d_score, 0);
    chk({tag, "_shots"}, d_shots, 0);
    chk({tag, "_go"}, d_go, 0);
    chk({tag, "_busy"}, d_busy, 0);
  endtask

  task automatic rd_check(input int r, input int c);
    int exp;
    rd_row = 4'(r); rd_col = 4'(c);
    @(negedge clk);
    exp = (r < 10 && c < 10) ? m_board[r * 10 + c] : 0;
    chk("rd_state", d_rd, exp);
  endtask

  // Drive one shot, hold the button `hold` extra cycles, then release.
  task automatic do_fire(input int r, input int c, input int hold, output logic [1:0] rd_at_ack);
    int n, res, extra;
    fire_row = 4'(r); fire_col = 4'(c); fire_req = 1'b1;
    rd_at_ack = d_rd;
    if (!m_play) begin
      extra = 0;
      for (int i = 0; i < 6; i++) begin @(negedge clk); if (d_ack) extra++; end
      chk("ignored_no_ack", extra, 0);
      chk("ignored_score", d_score, m_score);
      chk("ignored_shots", d_shots, m_shots);
      fire_req = 1'b0;
      @(negedge clk);
      return;
    end
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (d_ack) begin n = i; break; end
    end
    chk("ack_latency", n, 3);
    rd_at_ack = d_rd;
    m_shoot(r, c, res);
    chk("result", d_result, res);
    chk("score", d_score, m_score);
    chk("shots", d_shots, m_shots);
    chk("busy_resp", d_busy, 1);
    @(negedge clk);
    chk("ack_one_cycle", d_ack, 0);
    chk("game_over", d_go, m_over);
    extra = 0;
    for (int i = 0; i < hold; i++) begin @(negedge clk); if (d_ack) extra++; end
    chk("held_single_ack", extra, 0);
    fire_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [99:0] mask;
    logic [1:0]  rda;
    int          perm[100];
    int          n, tmp, j;

    reset_n = 1'b0; start = 1'b0; fire_req = 1'b0; ship_mask = '0;
    fire_row = '0; fire_col = '0; rd_row = '0; rd_col = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // IDLE ignores fire requests
    do_fire(1, 1, 0, rda);

    // single ship at 23; the SHIP_CELLS=1 instance ends its game on the hit
    mask = '0; mask[23] = 1'b1;
    do_start(mask);
    do_fire(2, 3, 0, rda);
    chk("one_game_over", o_go, 1);
    chk("one_score", o_score, 10);
    chk("one_shots", o_shots, 1);
    chk("one_result", o_result, 1);

    // miss at (0,0), read-during-write returns old value, then new value
    mask = '0;
    for (int i = 0; i < 100; i++) mask[i] = ($urandom_range(0, 7) == 0);
    mask[0] = 1'b0;
    do_start(mask);
    rd_row = 4'd0; rd_col = 4'd0;
    do_fire(0, 0, 0, rda);
    chk("rd_old_on_write", rda, 0);
    rd_check(0, 0);
    do_fire(0, 0, 0, rda);     // REPEAT
    do_fire(10, 4, 0, rda);    // INVALID
    do_fire(4, 10, 0, rda);    // INVALID
    do_fire(15, 15, 0, rda);   // INVALID
    rd_check(10, 4);
    rd_check(0, 0);

    // held button yields one ack; a new press yields another
    do_fire(7, 7, 50, rda);
    do_fire(7, 8, 0, rda);

    // random play
    for (int s = 0; s < 80; s++) begin
      do_fire($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 3), rda);
      if (s % 8 == 0) rd_check($urandom_range(0, 11), $urandom_range(0, 11));
    end

    // start during CHECK drops the shot and clears everything
    mask = '0;
    for (int i = 0; i < 100; i++) mask[i] = ($urandom_range(0, 7) == 0);
    do_start(mask);
    do_fire(0, 0, 0, rda);
    rd_check(0, 0);
    fire_row = 4'd5; fire_col = 4'd5; fire_req = 1'b1;
    @(negedge clk);
    chk("busy_check", d_busy, 1);
    fire_req = 1'b0;
    do_start(mask);
    n = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (d_ack) n++; end
    chk("start_drop_no_ack", n, 0);
    chk("start_clr_score", d_score, 0);
    chk("start_clr_shots", d_shots, 0);
    rd_check(0, 0);
    rd_check(5, 5);

    // full 17-ship game reaches OVER; counters then frozen
    for (int i = 0; i < 100; i++) perm[i] = i;
    for (int i = 99; i > 0; i--) begin
      j = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    mask = '0;
    for (int i = 0; i < 17; i++) mask[perm[i]] = 1'b1;
    do_start(mask);
    do_fire(perm[17] / 10, perm[17] % 10, 0, rda);
    for (int i = 0; i < 17; i++) do_fire(perm[i] / 10, perm[i] % 10, 0, rda);
    chk("over_score", d_score, 170);
    chk("over_shots", d_shots, 18);
    do_fire(perm[18] / 10, perm[18] % 10, 0, rda);
    chk("over_still", d_go, 1);

    // async reset in the RESP cycle
    mask = '0; mask[23] = 1'b1;
    do_start(mask);
    fire_row = 4'd2; fire_col = 4'd3; fire_req = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (d_ack) begin n = i; break; end
    end
    chk("rst_ack_latency", n, 3);
    reset_n = 1'b0;
    #1;
    chk_zero("mid_resp_reset");
    m_reset();
    fire_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_fire(2, 3, 0, rda);
    rd_check(2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
